// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone generator.
//   - wave_sel encodings
//   - envelope state enum
//   - noise LFSR seed, taps and single-step function
package tone_pkg;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_NOISE  = 2'd3;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois LFSR, right shift: taps are folded in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/tone_env.sv
// tone_env: linear attack/release envelope, advanced once per sample strobe.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   stb           sample strobe; the envelope only moves on this cycle
//   gate          note on (1) / off (0), sampled at stb
//   attack_step   increment per sample while gated; 0 jumps straight to max
//   release_step  decrement per sample after gate drops; 0 jumps straight to 0
//   env           current envelope level (0 .. 2^EW-1)
//   busy          envelope not idle, registered together with env
module tone_env
    import tone_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stb,
    input  logic          gate,
    input  logic [EW-1:0] attack_step,
    input  logic [EW-1:0] release_step,
    output logic [EW-1:0] env,
    output logic          busy
);

    localparam logic [EW-1:0] ENV_MAX = '1;

    env_state_t    state;
    env_state_t    state_nxt;
    logic [EW-1:0] env_nxt;
    logic [EW:0]   sum;

    // One extra bit so the attack add cannot wrap before it is compared with max.
    assign sum = {1'b0, env} + {1'b0, attack_step};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        if (gate) begin
            if (attack_step == '0 || sum >= {1'b0, ENV_MAX}) begin
                env_nxt   = ENV_MAX;
                state_nxt = ENV_SUSTAIN;
            end else begin
                env_nxt   = sum[EW-1:0];
                state_nxt = ENV_ATTACK;
            end
        end else begin
            // Retrigger falls out naturally: the gated branch starts from whatever env is.
            if (release_step == '0 || env <= release_step) begin
                env_nxt   = '0;
                state_nxt = ENV_IDLE;
            end else begin
                env_nxt   = env - release_step;
                state_nxt = ENV_RELEASE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ENV_IDLE;
            env   <= '0;
            busy  <= 1'b0;
        end else if (stb) begin
            state <= state_nxt;
            env   <= env_nxt;
            busy  <= (state_nxt != ENV_IDLE);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// tone_gen: phase-accumulator oscillator feeding an N-bit PWM DAC.
// A new sample is issued once per PWM period (when the local period counter
// wraps together with the DAC counter), so t_on never changes mid-period.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   fs_clk        tick enable shared with the DAC
//   freq_word     phase increment per sample
//   wave_sel      0 square, 1 saw, 2 triangle, 3 noise
//   gate          note on/off for the envelope
//   attack_step   envelope increment per sample (0 = instant)
//   release_step  envelope decrement per sample (0 = instant)
//   t_on          scaled sample to the DAC
//   sample_stb    one-cycle pulse in the cycle after t_on updates
//   busy          envelope not idle
module tone_gen
    import tone_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 16,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fs_clk,
    input  logic [PW-1:0] freq_word,
    input  logic [1:0]    wave_sel,
    input  logic          gate,
    input  logic [EW-1:0] attack_step,
    input  logic [EW-1:0] release_step,
    output logic [N-1:0]  t_on,
    output logic          sample_stb,
    output logic          busy
);

    logic [N-1:0]    ctr;
    logic            stb;
    logic [PW-1:0]   phase;
    logic [15:0]     lfsr;
    logic [N-1:0]    tri_q;
    logic [N-1:0]    raw;
    logic [N-1:0]    raw_q;
    logic [EW-1:0]   env;
    logic [N+EW-1:0] product;
    logic [N-1:0]    scaled;

    // Period strobe: last tick of the PWM period, aligned with the DAC's own wrap.
    assign stb = fs_clk && (ctr == '1);

    assign tri_q = phase[PW-2 -: N];

    always_comb begin
        raw = '0;
        case (wave_sel)
            WAVE_SQUARE: raw = phase[PW-1] ? '0 : '1;
            WAVE_SAW:    raw = phase[PW-1 -: N];
            WAVE_TRI:    raw = phase[PW-1] ? ~tri_q : tri_q;
            WAVE_NOISE:  raw = lfsr[15 -: N];
            default:     raw = '0;
        endcase
    end

    // Full scale passes the sample through untouched so max amplitude reaches 2^N-1.
    assign product = {{EW{1'b0}}, raw_q} * {{N{1'b0}}, env};
    assign scaled  = (env == '1) ? raw_q : product[N+EW-1 -: N];

    // The waveform value is captured one sample ahead of scaling: t_on combines the
    // previously captured waveform value with the current (pre-update) envelope.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr        <= '0;
            phase      <= '0;
            lfsr       <= LFSR_SEED;
            raw_q      <= '0;
            t_on       <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= stb;
            if (fs_clk) begin
                ctr <= ctr + N'(1);
            end
            if (stb) begin
                t_on  <= scaled;
                raw_q <= raw;
                phase <= phase + freq_word;
                lfsr  <= lfsr_next(lfsr);
            end
        end
    end

    tone_env #(
        .EW(EW)
    ) u_env (
        .clk          (clk),
        .reset        (reset),
        .stb          (stb),
        .gate         (gate),
        .attack_step  (attack_step),
        .release_step (release_step),
        .env          (env),
        .busy         (busy)
    );

endmodule
